pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 7 +
 rtl/pipe_data_reg.sv | 18 +
 rtl/pipe_skid_reg.sv | 94 +++++++++
 tb/tb_pipe_skid_reg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for elastic pipeline-stage registers: occupancy levels and default payload width.
package pipe_pkg;
   localparam logic [1:0] LVL_EMPTY = 2'd0;
   localparam logic [1:0] LVL_ONE   = 2'd1;
   localparam logic [1:0] LVL_FULL  = 2'd2;
   localparam int         PIPE_W    = 32;
endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable; synchronous clear takes priority over load.
// Latency 1 cycle; no flow control of its own (the owner decides when to load).
module pipe_data_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (clear)
         q <= '0;
      else if (load)
         q <= d;
   end
endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a one-entry skid buffer and a flush that squashes held words.
// Latency 1 cycle; in_ready is registered (!skid_valid), so out_ready never reaches in_ready combinationally.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH             = PIPE_W,
   parameter bit FLUSH_CLEARS_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       level
);
   logic             main_valid;
   logic             skid_valid;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic [WIDTH-1:0] main_d;
   logic             in_fire;
   logic             out_fire;
   logic             main_load;
   logic             skid_load;
   logic             data_clear;

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign level     = {1'b0, main_valid} + {1'b0, skid_valid};
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // When the skid holds a word it is always the next one out, so it refills main first.
   assign main_d     = skid_valid ? skid_data : in_data;
   assign data_clear = reset | (flush & FLUSH_CLEARS_DATA);

   always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      case (level)
         LVL_EMPTY: main_load = in_fire;
         LVL_ONE: begin
            main_load = in_fire & out_fire;
            skid_load = in_fire & ~out_fire;
         end
         LVL_FULL:  main_load = out_fire;
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         case (level)
            LVL_EMPTY: main_valid <= in_fire;
            LVL_ONE: begin
               if (out_fire && !in_fire)
                  main_valid <= 1'b0;
               else if (in_fire && !out_fire)
                  skid_valid <= 1'b1;
            end
            LVL_FULL: begin
               if (out_fire)
                  skid_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Loads are suppressed during flush so a retained-data flush really holds the old payload.
   pipe_data_reg #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .clear (data_clear),
      .load  (main_load & ~flush),
      .d     (main_d),
      .q     (main_data)
   );

   pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .clear (data_clear),
      .load  (skid_load & ~flush),
      .d     (in_data),
      .q     (skid_data)
   );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench: two instances (flush clears data / flush keeps data) against a queue model.
module tb_pipe_skid_reg;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [31:0] out_data_a, out_data_b;
   logic [1:0]  level_a, level_b;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Model: the words held by the stage, oldest first, plus what each main register shows when empty.
   logic [31:0] q[$];
   logic [31:0] resid_a = '0;
   logic [31:0] resid_b = '0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.WIDTH(32), .FLUSH_CLEARS_DATA(1'b1)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .level(level_a)
   );

   pipe_skid_reg #(.WIDTH(32), .FLUSH_CLEARS_DATA(1'b0)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .level(level_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      logic [31:0] popped;
      bit          room;
      if (reset) begin
         q.delete();
         resid_a = '0;
         resid_b = '0;
      end else if (flush) begin
         if (q.size() > 0) resid_b = q[0];
         q.delete();
         resid_a = '0;
      end else begin
         room = (q.size() < 2);
         if (q.size() > 0 && out_ready) begin
            popped = q.pop_front();
            if (q.size() == 0) begin
               resid_a = popped;
               resid_b = popped;
            end
         end
         if (in_valid && room) q.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("out_valid_a", {31'd0, out_valid_a}, {31'd0, q.size() > 0});
         chk("in_ready_a",  {31'd0, in_ready_a},  {31'd0, q.size() < 2});
         chk("level_a",     {30'd0, level_a},     q.size());
         chk("out_data_a",  out_data_a, (q.size() > 0) ? q[0] : resid_a);
         chk("out_valid_b", {31'd0, out_valid_b}, {31'd0, q.size() > 0});
         chk("in_ready_b",  {31'd0, in_ready_b},  {31'd0, q.size() < 2});
         chk("level_b",     {30'd0, level_b},     q.size());
         chk("out_data_b",  out_data_b, (q.size() > 0) ? q[0] : resid_b);
         chk("illegal_a", {31'd0, !out_valid_a && !in_ready_a}, 32'd0);
         chk("illegal_b", {31'd0, !out_valid_b && !in_ready_b}, 32'd0);
      end
   end

   // Apply one cycle of inputs and return just after the following negedge.
   task automatic cyc(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic ordy);
      reset     = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      #1;
   endtask

   initial begin
      @(negedge clk);
      #1;
      cyc(1, 0, 0, 32'h0, 0);
      cmp_en = 1'b1;
      chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
      chk("rst_out_data",  out_data_a, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready_a}, 32'd1);
      chk("rst_level",     {30'd0, level_a}, 32'd0);

      cyc(0, 0, 1, 32'h11, 1);
      chk("stream_11", out_data_a, 32'h11);
      chk("stream_11_model", q[0], 32'h11);
      cyc(0, 0, 1, 32'h22, 1);
      chk("stream_22", out_data_a, 32'h22);
      cyc(0, 0, 1, 32'h33, 1);
      chk("stream_33", out_data_a, 32'h33);
      chk("stream_level", {30'd0, level_a}, 32'd1);
      chk("stream_in_ready", {31'd0, in_ready_a}, 32'd1);
      cyc(0, 0, 0, 32'h0, 1);
      chk("stream_drained", {31'd0, out_valid_a}, 32'd0);

      cyc(0, 0, 1, 32'hA0, 0);
      cyc(0, 0, 1, 32'hA1, 0);
      chk("skid_level", {30'd0, level_a}, 32'd2);
      chk("skid_in_ready", {31'd0, in_ready_a}, 32'd0);
      chk("skid_model_size", q.size(), 32'd2);
      cyc(0, 0, 1, 32'hA2, 0);
      chk("skid_hold_A0", out_data_a, 32'hA0);
      cyc(0, 0, 1, 32'hA2, 1);
      chk("skid_out_A1", out_data_a, 32'hA1);
      cyc(0, 0, 1, 32'hA2, 1);
      chk("skid_out_A2", out_data_a, 32'hA2);
      cyc(0, 0, 0, 32'h0, 1);
      chk("skid_level_end", {30'd0, level_a}, 32'd0);

      cyc(0, 0, 1, 32'hB0, 0);
      cyc(0, 0, 1, 32'hB1, 0);
      cyc(0, 1, 0, 32'h0, 0);
      chk("flush_full_valid", {31'd0, out_valid_a}, 32'd0);
      chk("flush_full_data_a", out_data_a, 32'd0);
      chk("flush_full_in_ready", {31'd0, in_ready_a}, 32'd1);
      chk("flush_full_level", {30'd0, level_a}, 32'd0);
      chk("flush_keep_data_b", out_data_b, 32'hB0);
      chk("flush_keep_valid_b", {31'd0, out_valid_b}, 32'd0);

      cyc(0, 1, 1, 32'hC0, 1);
      chk("flush_drop_C0", {31'd0, out_valid_a}, 32'd0);
      chk("flush_drop_C0_b", out_data_b, 32'hB0);
      cyc(0, 0, 1, 32'hC1, 1);
      chk("after_flush_C1", out_data_a, 32'hC1);
      chk("after_flush_C1_valid", {31'd0, out_valid_a}, 32'd1);

      cyc(1, 1, 0, 32'h0, 0);
      chk("rst_flush_data_b", out_data_b, 32'd0);
      chk("rst_flush_level_b", {30'd0, level_b}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) != 0),
             $urandom,
             ($urandom_range(0, 2) != 0));
      end
      cyc(0, 0, 0, 32'h0, 1);
      cyc(0, 0, 0, 32'h0, 1);
      cmp_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
